pmem_write_buffer: RTL and testbench
====================================

Name: pmem_write_buffer

Overview:
- Sits between the prefetch buffer / L2 miss path and physical memory, and owns the physical memory port.
- Upstream read port: line reads from the prefetch stage. Upstream write port: L2 dirty-line writebacks.
- Writebacks are absorbed into a small FIFO so L2 does not stall on them, then drained to physical memory when no read is pending.
- Reads hitting a buffered line are forwarded from the buffer, preserving read-after-write ordering.

Parameters:
- DEPTH, 4, number of buffered lines (power of two, >=2).
- LOG_DEPTH, 2, log2(DEPTH); pointer width.
- BLOCK_WIDTH, 256, line width in bits (lc3b_block).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- up_read  in  1  line read request; held until up_resp.
- up_address  in  16  read address; byte offset [4:0] ignored for matching.
- up_rdata  out  BLOCK_WIDTH  read data; valid while up_resp=1.
- up_resp  out  1  read response, one cycle.
- up_write  in  1  writeback request; held until up_wresp.
- up_waddress  in  16  writeback address.
- up_wdata  in  BLOCK_WIDTH  writeback data.
- up_wresp  out  1  writeback accepted (combinational, same cycle as capture).
- pmem_read  out  1  physical memory read.
- pmem_write  out  1  physical memory write.
- pmem_address  out  16  physical memory address.
- pmem_wdata  out  BLOCK_WIDTH  physical memory write data.
- pmem_rdata  in  BLOCK_WIDTH  physical memory read data.
- pmem_resp  in  1  physical memory response, one cycle.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Storage:
  - DEPTH entries, each {valid, tag[15:5], data}.
  - head/tail pointers are LOG_DEPTH bits and wrap modulo DEPTH; count is LOG_DEPTH+1 bits.
- Reset:
  - State IDLE; all valid=0; head=tail=count=0.
  - pmem_read=pmem_write=0, up_resp=0, up_wresp forced 0, empty=1, full=0.
  - Reset mid-transaction abandons the pmem access and discards buffered lines.
- Write port (independent of FSM):
  - up_wresp = up_write & !reset & (!full | coalesce_hit).
  - Data captured at the edge ending the wresp cycle; entry pushed at tail; count+1.
  - When full and not coalescing, up_wresp stays 0; L2 stalls.
  - No same-cycle pop+push when full: the write is accepted the cycle after the pop.
- FSM states: IDLE, FWD, READ, DRAIN.
  - IDLE priority:
    - full -> DRAIN.
    - up_read & hit -> FWD.
    - up_read & !hit -> READ.
    - !empty -> DRAIN.
    - else stay IDLE.
  - hit: tag match on any valid entry, excluding a write arriving the same cycle (read is ordered before that write); youngest match wins.
  - FWD:
    - Entry data snapshotted into a register at the IDLE->FWD edge.
    - up_resp=1, up_rdata=snapshot for exactly one cycle -> IDLE. Latency 1 cycle.
  - READ:
    - pmem_read=1, pmem_address=up_address.
    - up_resp=pmem_resp, up_rdata=pmem_rdata.
    - On pmem_resp -> IDLE.
  - DRAIN:
    - pmem_write=1, pmem_address={head.tag,5'b0}, pmem_wdata=head.data.
    - Transaction is non-preemptible. On pmem_resp: pop head, count-1 -> IDLE.
    - A read arriving during DRAIN waits in IDLE arbitration.
- pmem_read and pmem_write are never asserted together.
- Upstream requesters are Moore: a request drops the cycle after its resp, so the block never sees a stale repeat.

Optional Feature:
- Macro: PMEM_WB_COALESCE_EN.
- Defined:
  - A write whose tag matches a valid entry overwrites that entry's data in place (coalesce_hit=1); no allocation, count unchanged, accepted even when full.
  - The head entry is excluded from coalescing while in DRAIN; such a write allocates a new entry instead.
- Undefined:
  - coalesce_hit=0; every accepted write allocates.
  - Forwarding uses the youngest matching entry.

Test Plan:
1. Reset; read miss 0x1240, pmem_resp 3 cycles later with D1 -> pmem_read=1, pmem_address=0x1240; up_resp in pmem_resp cycle with up_rdata=D1; pmem_read=0 next cycle.
2. Write 0x2000/A, no reads -> up_wresp same cycle; empty=0 next cycle; DRAIN drives pmem_write, address 0x2000, wdata A; after pmem_resp empty=1.
3. Write 0x2000/A, then read 0x2010 before drain -> FWD: up_resp one cycle after request, up_rdata=A, pmem_read never asserted.
4. pmem_resp held 0; write 0x1000, 0x1100, 0x1200, 0x1300 -> full=1; write 0x1400 gets up_wresp=0 until the 0x1000 drain completes, then is accepted; drain order 0x1000..0x1400.
5. Write 0x3000/A then 0x3000/B -> with PMEM_WB_COALESCE_EN, count=1 and one drain of B; without it, drains of A then B.
6. Reset asserted during READ -> next cycle pmem_read=0, up_resp=0, empty=1, state IDLE.

Source files
------------

// File: rtl/pmem_write_buffer.sv
// pmem_write_buffer: posted L2 writeback FIFO that owns the physical memory port and forwards reads from buffered lines.
// Optional build macro PMEM_WB_COALESCE_EN merges a writeback into a matching buffered line instead of allocating.

module pmem_write_buffer #(
    parameter int DEPTH       = 4,
    parameter int LOG_DEPTH   = 2,
    parameter int BLOCK_WIDTH = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   up_read,
    input  logic [15:0]            up_address,
    output logic [BLOCK_WIDTH-1:0] up_rdata,
    output logic                   up_resp,
    input  logic                   up_write,
    input  logic [15:0]            up_waddress,
    input  logic [BLOCK_WIDTH-1:0] up_wdata,
    output logic                   up_wresp,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [15:0]            pmem_address,
    output logic [BLOCK_WIDTH-1:0] pmem_wdata,
    input  logic [BLOCK_WIDTH-1:0] pmem_rdata,
    input  logic                   pmem_resp,
    output logic                   full,
    output logic                   empty
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [10:0]            tag_q  [DEPTH];
    logic [BLOCK_WIDTH-1:0] data_q [DEPTH];
    logic [LOG_DEPTH-1:0]   head_q, head_d;
    logic [LOG_DEPTH-1:0]   tail_q, tail_d;
    logic [LOG_DEPTH:0]     count_q, count_d;
    logic [BLOCK_WIDTH-1:0] snap_q;

    logic                   rd_hit_s;
    logic [LOG_DEPTH-1:0]   rd_idx_s;
    logic [LOG_DEPTH-1:0]   rd_scan_s;
    logic                   co_hit_s;
    logic [LOG_DEPTH-1:0]   co_idx_s;
    logic                   push_s;
    logic                   coal_s;
    logic                   pop_s;
    logic                   snap_load_s;
    logic                   unused_s;

    assign unused_s = ^{up_address[4:0], up_waddress[4:0]};

    assign full  = (count_q == (LOG_DEPTH+1)'(DEPTH));
    assign empty = (count_q == {(LOG_DEPTH+1){1'b0}});

    // Read lookup: scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        rd_hit_s  = 1'b0;
        rd_idx_s  = head_q;
        rd_scan_s = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            rd_scan_s = head_q + LOG_DEPTH'(i);
            rd_hit_s  = rd_hit_s | (valid_q[rd_scan_s] && (tag_q[rd_scan_s] == up_address[15:5]));
            rd_idx_s  = (valid_q[rd_scan_s] && (tag_q[rd_scan_s] == up_address[15:5])) ? rd_scan_s : rd_idx_s;
        end
    end

`ifdef PMEM_WB_COALESCE_EN
    logic [LOG_DEPTH-1:0] co_scan_s;
    logic                 co_match_s;

    // Coalesce lookup: the head line being drained is frozen, so it never absorbs a write.
    always_comb begin
        co_hit_s   = 1'b0;
        co_idx_s   = head_q;
        co_scan_s  = head_q;
        co_match_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            co_scan_s  = head_q + LOG_DEPTH'(i);
            co_match_s = valid_q[co_scan_s] && (tag_q[co_scan_s] == up_waddress[15:5])
                         && !((state_q == DRAIN) && (co_scan_s == head_q));
            co_hit_s   = co_hit_s | co_match_s;
            co_idx_s   = co_match_s ? co_scan_s : co_idx_s;
        end
    end
`else
    assign co_hit_s = 1'b0;
    assign co_idx_s = {LOG_DEPTH{1'b0}};
`endif

    assign up_wresp = up_write & ~reset & (~full | co_hit_s);
    assign push_s   = up_wresp & ~co_hit_s;
    assign coal_s   = up_wresp & co_hit_s;
    assign pop_s    = (state_q == DRAIN) & pmem_resp;

    // FIFO bookkeeping; push and pop never target the same slot because push is blocked when full.
    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + (LOG_DEPTH+1)'(push_s) - (LOG_DEPTH+1)'(pop_s);
        if (pop_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + LOG_DEPTH'(1);
        end else begin
            head_d = head_q;
        end
        if (push_s) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + LOG_DEPTH'(1);
        end else begin
            tail_d = tail_q;
        end
    end

    // Arbitration and physical memory port drive.
    always_comb begin
        state_d      = state_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = {BLOCK_WIDTH{1'b0}};
        up_resp      = 1'b0;
        up_rdata     = {BLOCK_WIDTH{1'b0}};
        snap_load_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (full) begin
                    state_d = DRAIN;
                end else if (up_read && rd_hit_s) begin
                    state_d     = FWD;
                    snap_load_s = 1'b1;
                end else if (up_read) begin
                    state_d = READ;
                end else if (!empty) begin
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end
            FWD: begin
                up_resp  = 1'b1;
                up_rdata = snap_q;
                state_d  = IDLE;
            end
            READ: begin
                pmem_read    = 1'b1;
                pmem_address = up_address;
                up_resp      = pmem_resp;
                up_rdata     = pmem_rdata;
                state_d      = pmem_resp ? IDLE : READ;
            end
            DRAIN: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[head_q], 5'b00000};
                pmem_wdata   = data_q[head_q];
                state_d      = pmem_resp ? IDLE : DRAIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and pointer registers; reset discards every buffered line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= {DEPTH{1'b0}};
            head_q  <= {LOG_DEPTH{1'b0}};
            tail_q  <= {LOG_DEPTH{1'b0}};
            count_q <= {(LOG_DEPTH+1){1'b0}};
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Line storage; the snapshot is taken before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q <= {BLOCK_WIDTH{1'b0}};
        end else begin
            if (snap_load_s) begin
                snap_q <= data_q[rd_idx_s];
            end
            if (push_s) begin
                tag_q[tail_q]  <= up_waddress[15:5];
                data_q[tail_q] <= up_wdata;
            end else if (coal_s) begin
                data_q[co_idx_s] <= up_wdata;
            end
        end
    end

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Self-checking bench for pmem_write_buffer: directed scenarios plus randomized traffic checked
// against an architectural memory model (a read returns the latest accepted write to its line).

module tb_pmem_write_buffer;

    localparam int BW = 256;

    typedef struct packed {
        logic [15:0]   addr;
        logic [BW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          up_read;
    logic [15:0]   up_address;
    logic [BW-1:0] up_rdata;
    logic          up_resp;
    logic          up_write;
    logic [15:0]   up_waddress;
    logic [BW-1:0] up_wdata;
    logic          up_wresp;
    logic          pmem_read;
    logic          pmem_write;
    logic [15:0]   pmem_address;
    logic [BW-1:0] pmem_wdata;
    logic [BW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic          full;
    logic          empty;

    int  errors = 0;
    int  checks = 0;
    bit  hold_resp;
    int  fixed_lat;
    bit  busy;
    int  cnt;
    bit  saw_rd;

    logic [BW-1:0] mem   [int];
    logic [BW-1:0] model [int];
    wr_t           drain_log [$];
    wr_t           acc_q     [$];

    pmem_write_buffer #(.DEPTH(4), .LOG_DEPTH(2), .BLOCK_WIDTH(BW)) dut (
        .clk(clk), .reset(reset),
        .up_read(up_read), .up_address(up_address), .up_rdata(up_rdata), .up_resp(up_resp),
        .up_write(up_write), .up_waddress(up_waddress), .up_wdata(up_wdata), .up_wresp(up_wresp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] init_line(input int line);
        logic [31:0] w;
        w = (32'(line) * 32'h9E3779B1) ^ 32'h5A5A0000;
        return {8{w}};
    endfunction

    function automatic logic [BW-1:0] read_mem(input int line);
        if (mem.exists(line)) return mem[line];
        return init_line(line);
    endfunction

    function automatic logic [BW-1:0] rnd_line();
        logic [BW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Physical memory responder, acting just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (pmem_read === 1'b1) saw_rd = 1'b1;
        if (pmem_read === 1'b1 || pmem_write === 1'b1) begin
            checks++;
            if (pmem_read === 1'b1 && pmem_write === 1'b1) begin
                errors++;
                $display("FAIL rd_wr_exclusive pmem_read=%b pmem_write=%b required not both 1", pmem_read, pmem_write);
            end
        end
        if (pmem_resp) begin
            pmem_resp = 1'b0;
        end else if (!(pmem_read === 1'b1 || pmem_write === 1'b1)) begin
            busy = 1'b0;
        end else if (!hold_resp) begin
            if (!busy) begin
                busy = 1'b1;
                cnt  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
            if (cnt == 0) begin
                busy      = 1'b0;
                pmem_resp = 1'b1;
                if (pmem_write) begin
                    mem[int'(pmem_address[15:5])] = pmem_wdata;
                    drain_log.push_back('{pmem_address, pmem_wdata});
                end else begin
                    pmem_rdata = read_mem(int'(pmem_address[15:5]));
                end
            end else begin
                cnt--;
            end
        end
    end

    task automatic do_write(input logic [15:0] a, input logic [BW-1:0] d);
        bit ok = 1'b0;
        up_write = 1'b1; up_waddress = a; up_wdata = d;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (up_wresp === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        up_write = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL write_accept addr=%h up_wresp never 1, required 1", a); end
    endtask

    task automatic do_read(input logic [15:0] a, output logic [BW-1:0] d, output int lat);
        bit ok = 1'b0;
        d = '0; lat = -1;
        up_read = 1'b1; up_address = a;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (up_resp === 1'b1) begin ok = 1'b1; d = up_rdata; lat = n; break; end
            @(negedge clk);
        end
        @(negedge clk);
        up_read = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL read_resp addr=%h up_resp never 1, required 1", a); end
    endtask

    task automatic wait_empty();
        bit ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            #1;
            if (empty === 1'b1 && pmem_write === 1'b0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL drain_done empty=%b pmem_write=%b required 1/0", empty, pmem_write); end
    endtask

    task automatic test_reset();
        reset = 1'b1; up_write = 1'b1; up_waddress = 16'h0040;
        repeat (2) @(negedge clk);
        #1;
        checks += 6;
        if (full !== 1'b0)       begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        if (empty !== 1'b1)      begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        if (pmem_read !== 1'b0)  begin errors++; $display("FAIL reset_pmem_read got=%b exp=0", pmem_read); end
        if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write got=%b exp=0", pmem_write); end
        if (up_resp !== 1'b0)    begin errors++; $display("FAIL reset_up_resp got=%b exp=0", up_resp); end
        if (up_wresp !== 1'b0)   begin errors++; $display("FAIL reset_up_wresp got=%b exp=0", up_wresp); end
        up_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_miss();
        logic [BW-1:0] d1 = rnd_line();
        int n;
        mem[int'(16'h1240 >> 5)] = d1;
        hold_resp = 1'b0; fixed_lat = 2;
        up_read = 1'b1; up_address = 16'h1240;
        @(negedge clk); #1;
        checks += 3;
        if (pmem_read !== 1'b1)        begin errors++; $display("FAIL miss_pmem_read got=%b exp=1", pmem_read); end
        if (pmem_address !== 16'h1240) begin errors++; $display("FAIL miss_pmem_addr got=%h exp=1240", pmem_address); end
        if (up_resp !== 1'b0)          begin errors++; $display("FAIL miss_early_resp got=%b exp=0", up_resp); end
        for (n = 0; n < 20; n++) begin
            if (up_resp === 1'b1) break;
            @(negedge clk); #1;
        end
        checks += 3;
        if (n != 2)            begin errors++; $display("FAIL miss_latency got=%0d exp=2", n); end
        if (pmem_resp !== 1'b1) begin errors++; $display("FAIL miss_resp_align pmem_resp=%b exp=1", pmem_resp); end
        if (up_rdata !== d1)   begin errors++; $display("FAIL miss_rdata got=%h exp=%h", up_rdata, d1); end
        @(negedge clk);
        up_read = 1'b0;
        #1;
        checks += 2;
        if (pmem_read !== 1'b0) begin errors++; $display("FAIL miss_release got=%b exp=0", pmem_read); end
        if (up_resp !== 1'b0)   begin errors++; $display("FAIL miss_resp_once got=%b exp=0", up_resp); end
        fixed_lat = -1;
        @(negedge clk);
    endtask

    task automatic test_drain();
        logic [BW-1:0] a = rnd_line();
        drain_log.delete();
        hold_resp = 1'b1;
        do_write(16'h2000, a);
        #1;
        checks++;
        if (empty !== 1'b0) begin errors++; $display("FAIL drain_not_empty got=%b exp=0", empty); end
        @(negedge clk); #1;
        checks += 4;
        if (pmem_write !== 1'b1)       begin errors++; $display("FAIL drain_pmem_write got=%b exp=1", pmem_write); end
        if (pmem_read !== 1'b0)        begin errors++; $display("FAIL drain_pmem_read got=%b exp=0", pmem_read); end
        if (pmem_address !== 16'h2000) begin errors++; $display("FAIL drain_addr got=%h exp=2000", pmem_address); end
        if (pmem_wdata !== a)          begin errors++; $display("FAIL drain_wdata got=%h exp=%h", pmem_wdata, a); end
        @(negedge clk);
        fixed_lat = 0; hold_resp = 1'b0;
        wait_empty();
        checks++;
        if (drain_log.size() != 1 || drain_log[0].addr !== 16'h2000 || drain_log[0].data !== a) begin
            errors++; $display("FAIL drain_log size=%0d exp=1 entry 2000", drain_log.size());
        end
        fixed_lat = -1;
        @(negedge clk);
    endtask

    task automatic test_forward();
        logic [BW-1:0] a = rnd_line();
        logic [BW-1:0] rd;
        int lat;
        hold_resp = 1'b1;
        do_write(16'h2000, a);
        saw_rd = 1'b0;
        do_read(16'h2010, rd, lat);
        checks += 3;
        if (lat != 1)     begin errors++; $display("FAIL fwd_latency got=%0d exp=1", lat); end
        if (rd !== a)     begin errors++; $display("FAIL fwd_rdata got=%h exp=%h", rd, a); end
        if (saw_rd !== 1'b0) begin errors++; $display("FAIL fwd_no_pmem_read got=%b exp=0", saw_rd); end
        hold_resp = 1'b0;
        wait_empty();
        drain_log.delete();
        @(negedge clk);
    endtask

    task automatic test_full();
        logic [BW-1:0] d [5];
        bit got = 1'b0;
        for (int i = 0; i < 5; i++) d[i] = rnd_line();
        drain_log.delete();
        hold_resp = 1'b1;
        for (int i = 0; i < 4; i++) do_write(16'h1000 + 16'(i * 256), d[i]);
        #1;
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", full); end
        up_write = 1'b1; up_waddress = 16'h1400; up_wdata = d[4];
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (up_wresp !== 1'b0) begin errors++; $display("FAIL full_stall cycle=%0d got=%b exp=0", k, up_wresp); end
            @(negedge clk);
        end
        fixed_lat = 0; hold_resp = 1'b0;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (up_wresp === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        checks += 2;
        if (!got) begin errors++; $display("FAIL full_accept up_wresp never 1, required 1"); end
        if (drain_log.size() != 1 || pmem_resp !== 1'b0) begin
            errors++; $display("FAIL full_accept_timing drains=%0d pmem_resp=%b exp 1/0", drain_log.size(), pmem_resp);
        end
        @(negedge clk);
        up_write = 1'b0;
        wait_empty();
        checks++;
        if (drain_log.size() != 5) begin errors++; $display("FAIL full_drain_count got=%0d exp=5", drain_log.size()); end
        for (int i = 0; i < 5 && i < drain_log.size(); i++) begin
            checks++;
            if (drain_log[i].addr !== 16'h1000 + 16'(i * 256) || drain_log[i].data !== d[i]) begin
                errors++; $display("FAIL full_drain_order idx=%0d got=%h exp=%h", i, drain_log[i].addr, 16'h1000 + 16'(i * 256));
            end
        end
        fixed_lat = -1;
        drain_log.delete();
        @(negedge clk);
    endtask

    task automatic test_coalesce();
        logic [BW-1:0] x = rnd_line();
        logic [BW-1:0] a = rnd_line();
        logic [BW-1:0] b = rnd_line();
        logic [BW-1:0] rd;
        int lat;
        wr_t exp_q [$];
        drain_log.delete();
        hold_resp = 1'b1;
        do_write(16'h5000, x);
        do_write(16'h3000, a);
        do_write(16'h3004, b);
        fixed_lat = 1; hold_resp = 1'b0;
        do_read(16'h3008, rd, lat);
        checks++;
        if (rd !== b) begin errors++; $display("FAIL coal_fwd_youngest got=%h exp=%h", rd, b); end
        wait_empty();
        exp_q.push_back('{16'h5000, x});
`ifndef PMEM_WB_COALESCE_EN
        exp_q.push_back('{16'h3000, a});
`endif
        exp_q.push_back('{16'h3000, b});
        checks++;
        if (drain_log.size() != exp_q.size()) begin
            errors++; $display("FAIL coal_drain_count got=%0d exp=%0d", drain_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < drain_log.size(); i++) begin
            checks++;
            if (drain_log[i] !== exp_q[i]) begin
                errors++; $display("FAIL coal_drain idx=%0d got=%h exp=%h", i, drain_log[i].addr, exp_q[i].addr);
            end
        end
        fixed_lat = -1;
        drain_log.delete();
        @(negedge clk);
    endtask

    task automatic test_head_excl();
        logic [BW-1:0] p = rnd_line();
        logic [BW-1:0] q = rnd_line();
        drain_log.delete();
        hold_resp = 1'b1;
        do_write(16'h6000, p);
        @(negedge clk);
        do_write(16'h6000, q);
        hold_resp = 1'b0;
        wait_empty();
        checks++;
        if (drain_log.size() != 2) begin errors++; $display("FAIL head_excl_count got=%0d exp=2", drain_log.size()); end
        else begin
            checks += 2;
            if (drain_log[0].data !== p) begin errors++; $display("FAIL head_excl_first got=%h exp=%h", drain_log[0].data, p); end
            if (drain_log[1].data !== q) begin errors++; $display("FAIL head_excl_second got=%h exp=%h", drain_log[1].data, q); end
        end
        drain_log.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        drain_log.delete();
        hold_resp = 1'b1;
        up_read = 1'b1; up_address = 16'h7000;
        up_write = 1'b1; up_waddress = 16'h7100; up_wdata = rnd_line();
        #1;
        checks++;
        if (up_wresp !== 1'b1) begin errors++; $display("FAIL rst_mid_wresp got=%b exp=1", up_wresp); end
        @(negedge clk);
        up_write = 1'b0;
        #1;
        checks += 2;
        if (pmem_read !== 1'b1) begin errors++; $display("FAIL rst_mid_in_read got=%b exp=1", pmem_read); end
        if (empty !== 1'b0)     begin errors++; $display("FAIL rst_mid_buffered got=%b exp=0", empty); end
        @(negedge clk);
        reset = 1'b1; up_read = 1'b0;
        @(negedge clk); #1;
        checks += 5;
        if (pmem_read !== 1'b0)  begin errors++; $display("FAIL rst_mid_pmem_read got=%b exp=0", pmem_read); end
        if (pmem_write !== 1'b0) begin errors++; $display("FAIL rst_mid_pmem_write got=%b exp=0", pmem_write); end
        if (up_resp !== 1'b0)    begin errors++; $display("FAIL rst_mid_up_resp got=%b exp=0", up_resp); end
        if (empty !== 1'b1)      begin errors++; $display("FAIL rst_mid_empty got=%b exp=1", empty); end
        if (full !== 1'b0)       begin errors++; $display("FAIL rst_mid_full got=%b exp=0", full); end
        reset = 1'b0; hold_resp = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (drain_log.size() != 0) begin errors++; $display("FAIL rst_mid_discard drains=%0d exp=0", drain_log.size()); end
    endtask

    task automatic test_random();
        logic [BW-1:0] d;
        logic [BW-1:0] rd;
        logic [BW-1:0] exp_d;
        logic [15:0]   al;
        int lat, line;
        drain_log.delete(); acc_q.delete(); model.delete();
        fixed_lat = -1; hold_resp = 1'b0;
        for (int op = 0; op < 80; op++) begin
            al   = 16'h8000 + 16'($urandom_range(0, 5) * 32);
            line = int'(al[15:5]);
            if ($urandom_range(0, 1) == 1) begin
                d = rnd_line();
                do_write(al | 16'($urandom_range(0, 31)), d);
                model[line] = d;
                acc_q.push_back('{al, d});
            end else begin
                do_read(al | 16'($urandom_range(0, 31)), rd, lat);
                exp_d = model.exists(line) ? model[line] : init_line(line);
                checks++;
                if (rd !== exp_d) begin errors++; $display("FAIL rand_read op=%0d addr=%h got=%h exp=%h", op, al, rd, exp_d); end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_empty();
`ifndef PMEM_WB_COALESCE_EN
        checks++;
        if (drain_log.size() != acc_q.size()) begin
            errors++; $display("FAIL rand_drain_count got=%0d exp=%0d", drain_log.size(), acc_q.size());
        end
        for (int i = 0; i < acc_q.size() && i < drain_log.size(); i++) begin
            checks++;
            if (drain_log[i] !== acc_q[i]) begin
                errors++; $display("FAIL rand_drain_order idx=%0d got=%h exp=%h", i, drain_log[i].addr, acc_q[i].addr);
            end
        end
`endif
        for (int k = 0; k < 6; k++) begin
            line = int'(16'(16'h8000 + 16'(k * 32)) >> 5);
            if (model.exists(line)) begin
                checks++;
                if (read_mem(line) !== model[line]) begin
                    errors++; $display("FAIL rand_final_mem line=%0d got=%h exp=%h", line, read_mem(line), model[line]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; up_read = 1'b0; up_address = 16'h0000;
        up_write = 1'b0; up_waddress = 16'h0000; up_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        hold_resp = 1'b1; fixed_lat = -1; busy = 1'b0; cnt = 0; saw_rd = 1'b0;
        test_reset();
        test_read_miss();
        test_drain();
        test_forward();
        test_full();
        test_coalesce();
        test_head_excl();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
